ripple_count_sampler: RTL

- Downstream consumer of the 4-bit ripple counter output `q`.
- Ripple outputs settle bit-by-bit and are asynchronous to the system clock, so this block synchronises `q` and filters out transient values.
- It checks that the count advances monotonically, detects 15->0 wraps and keeps a wrap counter.
- Accepted counts are delivered to a downstream consumer over a valid/ready handshake.

---
 rtl/rcs_pkg.sv | 14 +
 rtl/rcs_sync_filter.sv | 54 +++++
 rtl/ripple_count_sampler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rcs_pkg.sv
// Shared types and default sizing for the ripple-count sampler.
package rcs_pkg;

  localparam int unsigned CNT_W_DEF    = 4;
  localparam int unsigned STABLE_N_DEF = 2;
  localparam int unsigned WRAP_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_RESYNC = 2'd2
  } rcs_state_e;

endpackage

// File: rtl/rcs_sync_filter.sv
// Two-flop synchroniser followed by a STABLE_N-sample stability filter.
module rcs_sync_filter
  import rcs_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned STABLE_N = STABLE_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] q_in,
  output logic             stable,
  output logic [CNT_W-1:0] s2
);

  localparam int unsigned   SW       = $clog2(STABLE_N);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_N - 1);

  logic [CNT_W-1:0] s1_q, s1_d;
  logic [CNT_W-1:0] s2_q, s2_d;
  logic [1:0]       vld_q, vld_d;
  logic [SW-1:0]    stab_q, stab_d;

  // vld_q tracks whether s1/s2 hold real samples rather than reset zeros,
  // so a reset value is never mistaken for a stable count.
  always_comb begin
    s1_d   = q_in;
    s2_d   = s1_q;
    vld_d  = {vld_q[0], 1'b1};
    stab_d = stab_q;
    if (!vld_q[1] || (s1_q != s2_q)) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      vld_q  <= '0;
      stab_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      vld_q  <= vld_d;
      stab_q <= stab_d;
    end
  end

  assign stable = (stab_q == STAB_MAX);
  assign s2     = s2_q;

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple count, checks monotonic stepping and wraps,
// and hands accepted counts downstream. Option: RCS_SKIP_TOLERATE_EN (+2 steps).
module ripple_count_sampler
  import rcs_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned STABLE_N = STABLE_N_DEF,
  parameter int unsigned WRAP_W   = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              cnt_clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic              ovf
);

  logic             stable;
  logic [CNT_W-1:0] s2;

  rcs_sync_filter #(
    .CNT_W    (CNT_W),
    .STABLE_N (STABLE_N)
  ) u_sync_filter (
    .clk    (clk),
    .rst    (rst),
    .q_in   (q_in),
    .stable (stable),
    .s2     (s2)
  );

  rcs_state_e        state_q, state_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              clr_seen_q, clr_seen_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_wrap_q, out_wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              acc_wrap;
  logic [CNT_W-1:0]  step;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    clr_seen_d  = clr_seen_q | cnt_clr;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_wrap_d  = out_wrap_q;
    wrap_cnt_d  = wrap_cnt_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    accept      = 1'b0;
    acc_wrap    = 1'b0;
    step        = s2 - last_q;

    case (state_q)
      ST_INIT: begin
        if (stable) begin
          last_d  = s2;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (stable && (s2 != last_q)) begin
          if (step == CNT_W'(1)) begin
            accept   = 1'b1;
            acc_wrap = (s2 == '0);
`ifdef RCS_SKIP_TOLERATE_EN
          end else if (step == CNT_W'(2)) begin
            // a +2 step crosses max->0 exactly when it lands on 0 or 1
            accept   = 1'b1;
            acc_wrap = (s2 < CNT_W'(2));
`endif
          end else if ((s2 == '0) && (clr_seen_q || cnt_clr)) begin
            accept = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESYNC;
          end
        end
      end
      ST_RESYNC: begin
        if (stable) begin
          last_d     = s2;
          clr_seen_d = 1'b0;
          state_d    = ST_TRACK;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (accept) begin
      last_d     = s2;
      clr_seen_d = 1'b0;
      if (acc_wrap) begin
        wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
    end

    // Single-entry output: a stalled entry keeps its data, new accepts drop.
    if (accept && out_valid_q && !out_ready) begin
      ovf_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_count_d = s2;
      out_wrap_d  = acc_wrap;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      last_q      <= '0;
      clr_seen_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_wrap_q  <= 1'b0;
      wrap_cnt_q  <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      clr_seen_q  <= clr_seen_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_wrap_q  <= out_wrap_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_wrap  = out_wrap_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule
